// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the RV32I 5-stage core.
// Generates stage enables/flushes for load-use stalls, taken-branch flushes and
// data-memory wait states with timeout abort, selects EX operand forwarding, and
// keeps saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic             load_ex,
  input  logic             reg_wr_ex,
  input  logic             branch_taken_ex,
  input  logic [4:0]       rd_mem,
  input  logic             reg_wr_mem,
  input  logic             dm_req_mem,
  input  logic             dm_ready,
  input  logic [4:0]       rd_wb,
  input  logic             reg_wr_wb,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dm_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Wide enough to hold MEM_TIMEOUT itself; with the timeout disabled it may wrap freely.
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  // Enables packed as {pc, if_id, id_ex, ex_mem, mem_wb}; flushes as {if_id, id_ex, mem_wb}.
  logic [4:0] en;
  logic [2:0] flush;
  logic       err;
  logic       branch_evt;
  logic       load_use;
  logic       mem_stall;

  assign load_use = load_ex && reg_wr_ex && (rd_ex != 5'd0) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));

  assign mem_stall = dm_req_mem && !dm_ready;

  // Stage control decode. These are combinational on purpose: a hazard seen this
  // cycle must hold the pipe registers at the very next edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    en         = 5'b11111;
    flush      = 3'b000;
    err        = 1'b0;
    branch_evt = 1'b0;
    if (rst) begin
      en    = 5'b00000;
      flush = 3'b111;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            en    = 5'b00000;
            flush = 3'b001;
          end else if (branch_taken_ex) begin
            flush      = 3'b110;
            branch_evt = 1'b1;
          end else if (load_use) begin
            en    = 5'b00111;
            flush = 3'b010;
          end
        end
        MEM_WAIT: begin
          // Bubble into WB while frozen so the held MEM instr does not write the rf twice.
          if (!dm_ready) begin
            en    = 5'b00000;
            flush = 3'b001;
          end
        end
        ERR: begin
          err   = 1'b1;
          flush = 3'b001;
        end
        default: ;
      endcase
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
  assign {if_id_flush, id_ex_flush, mem_wb_flush}          = flush;
  assign dm_err = err;

  // EX operand forwarding: the younger MEM result wins over WB; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (reg_wr_mem && (rd_mem != 5'd0) && (rd_mem == rs1_ex))   fwd_a = 2'b10;
      else if (reg_wr_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex)) fwd_a = 2'b01;
      if (reg_wr_mem && (rd_mem != 5'd0) && (rd_mem == rs2_ex))   fwd_b = 2'b10;
      else if (reg_wr_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex)) fwd_b = 2'b01;
    end
  end

  // Memory-wait FSM: RUN -> MEM_WAIT on a stalled access, ERR for one cycle on timeout.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dm_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_V)) begin
            state    <= ERR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        ERR:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters: frozen-PC cycles and taken-branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en[4] && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, each cycle compared against a transaction-level reference model.
module tb_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used_id;
    logic       rs2_used_id;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic [4:0] rd_ex;
    logic       load_ex;
    logic       reg_wr_ex;
    logic       branch_taken_ex;
    logic [4:0] rd_mem;
    logic       reg_wr_mem;
    logic       dm_req_mem;
    logic       dm_ready;
    logic [4:0] rd_wb;
    logic       reg_wr_wb;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, dm_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(cur.rst),
    .rs1_id(cur.rs1_id), .rs2_id(cur.rs2_id),
    .rs1_used_id(cur.rs1_used_id), .rs2_used_id(cur.rs2_used_id),
    .rs1_ex(cur.rs1_ex), .rs2_ex(cur.rs2_ex), .rd_ex(cur.rd_ex),
    .load_ex(cur.load_ex), .reg_wr_ex(cur.reg_wr_ex),
    .branch_taken_ex(cur.branch_taken_ex),
    .rd_mem(cur.rd_mem), .reg_wr_mem(cur.reg_wr_mem),
    .dm_req_mem(cur.dm_req_mem), .dm_ready(cur.dm_ready),
    .rd_wb(cur.rd_wb), .reg_wr_wb(cur.reg_wr_wb),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .dm_err(dm_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // Reference model state: how many cycles the current access has been frozen,
  // whether an abort is due this cycle, and the expected event counts.
  int m_frozen = 0;
  bit m_abort  = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", tag, step_no, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
    if (s.reg_wr_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'b10;
    if (s.reg_wr_wb && s.rd_wb != 0 && s.rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Drive one cycle of inputs, compare all outputs against the model, advance the model.
  task automatic step(input stim_t s);
    logic [4:0] en;
    logic [2:0] fl;
    logic       err;
    logic [1:0] fa, fb;
    bit         br, lu;
    @(negedge clk);
    cur = s;
    step_no++;
    #1;
    if (s.rst) begin
      m_frozen = 0; m_abort = 1'b0; m_stall = 0; m_flush = 0;
    end
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    en = 5'b11111; fl = 3'b000; err = 1'b0; br = 1'b0;
    fa = fwd_ref(s.rs1_ex, s);
    fb = fwd_ref(s.rs2_ex, s);
    lu = s.load_ex && s.reg_wr_ex && s.rd_ex != 0 &&
         ((s.rs1_used_id && s.rs1_id == s.rd_ex) || (s.rs2_used_id && s.rs2_id == s.rd_ex));
    if (s.rst) begin
      en = 5'b00000; fl = 3'b111; fa = 2'b00; fb = 2'b00;
    end else if (m_abort) begin
      fl = 3'b001; err = 1'b1; m_abort = 1'b0;
    end else if (m_frozen > 0 || (s.dm_req_mem && !s.dm_ready)) begin
      if (m_frozen > 0 && s.dm_ready) begin
        m_frozen = 0;
      end else begin
        en = 5'b00000; fl = 3'b001;
        m_frozen++;
        if (TO != 0 && m_frozen == TO + 1) begin
          m_abort = 1'b1; m_frozen = 0;
        end
      end
    end else if (s.branch_taken_ex) begin
      fl = 3'b110; br = 1'b1;
    end else if (lu) begin
      en = 5'b00111; fl = 3'b010;
    end
    check("enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(en));
    check("flushes", 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 32'(fl));
    check("dm_err", 32'(dm_err), 32'(err));
    check("fwd_a", 32'(fwd_a), 32'(fa));
    check("fwd_b", 32'(fwd_b), 32'(fb));
    if (!s.rst) begin
      if (!en[4] && m_stall < CMAX) m_stall++;
      if (br && m_flush < CMAX) m_flush++;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst             = ($urandom_range(99) == 0);
    s.rs1_id          = 5'($urandom_range(3));
    s.rs2_id          = 5'($urandom_range(3));
    s.rs1_used_id     = 1'($urandom);
    s.rs2_used_id     = 1'($urandom);
    s.rs1_ex          = 5'($urandom_range(3));
    s.rs2_ex          = 5'($urandom_range(3));
    s.rd_ex           = 5'($urandom_range(3));
    s.load_ex         = 1'($urandom);
    s.reg_wr_ex       = ($urandom_range(3) != 0);
    s.branch_taken_ex = ($urandom_range(6) == 0);
    s.rd_mem          = 5'($urandom_range(3));
    s.reg_wr_mem      = 1'($urandom);
    s.dm_req_mem      = ($urandom_range(3) == 0);
    s.dm_ready        = ($urandom_range(2) == 0);
    s.rd_wb           = 5'($urandom_range(3));
    s.reg_wr_wb       = 1'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1'b1;

    // Reset state.
    s = idle(); s.rst = 1'b1;
    step(s);
    step(s);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_mem_wb_flush", 32'(mem_wb_flush), 32'd1);

    // Load-use stall on rs1.
    s = idle(); s.load_ex = 1; s.reg_wr_ex = 1; s.rd_ex = 5; s.rs1_id = 5; s.rs1_used_id = 1;
    step(s);
    check("lu_pc_en", 32'(pc_en), 32'd0);
    check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    step(idle());
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load into x0 never stalls.
    s.rd_ex = 0; s.rs1_id = 0;
    step(s);
    check("x0_pc_en", 32'(pc_en), 32'd1);

    // Taken branch overrides a simultaneous load-use.
    s = idle(); s.load_ex = 1; s.reg_wr_ex = 1; s.rd_ex = 5; s.rs1_id = 5; s.rs1_used_id = 1;
    s.branch_taken_ex = 1;
    step(s);
    check("br_if_id_flush", 32'(if_id_flush), 32'd1);
    check("br_pc_en", 32'(pc_en), 32'd1);
    step(idle());
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Data-memory wait: three frozen cycles, then the completing cycle advances.
    s = idle(); s.dm_req_mem = 1;
    for (int i = 0; i < 3; i++) begin
      step(s);
      check("mw_frozen", 32'({pc_en, mem_wb_en, mem_wb_flush}), 32'b001);
    end
    s.dm_ready = 1;
    step(s);
    check("mw_done", 32'({pc_en, mem_wb_en, mem_wb_flush, dm_err}), 32'b1100);
    step(idle());
    check("mw_stall_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: five frozen cycles then a one-cycle abort pulse, back to RUN.
    s = idle(); s.dm_req_mem = 1;
    for (int i = 0; i < 5; i++) begin
      step(s);
      check("to_no_err", 32'({pc_en, dm_err}), 32'b00);
    end
    step(s);
    check("to_err", 32'({dm_err, pc_en, mem_wb_flush}), 32'b111);
    step(idle());
    check("to_after", 32'({dm_err, pc_en, mem_wb_flush}), 32'b010);

    // Forwarding priority.
    s = idle(); s.rd_mem = 7; s.rd_wb = 7; s.reg_wr_mem = 1; s.reg_wr_wb = 1;
    s.rs1_ex = 7; s.rs2_ex = 7;
    step(s);
    check("fwd_mem", 32'({fwd_a, fwd_b}), 32'b1010);
    s.reg_wr_mem = 0;
    step(s);
    check("fwd_wb", 32'({fwd_a, fwd_b}), 32'b0101);
    s.rd_wb = 0; s.rs1_ex = 0; s.rs2_ex = 0;
    step(s);
    check("fwd_x0", 32'({fwd_a, fwd_b}), 32'b0000);

    // Random traffic, including occasional mid-wait resets and counter saturation.
    for (int i = 0; i < 1500; i++) step(rand_stim());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
